fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer_if.sv | 43 ++++
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Bundle of every signal the fetch sequencer exchanges with the program
// counter, instruction memory, decode and execute.
//
// master modport : the fetch sequencer itself
// slave  modport : its environment (counter, memory, decode, execute)
//
// Counter side : PcValue in; PcLoadEnable, PcLoadValue, PcOffsetEnable, PcOffset out
// Memory side  : MemReq, MemAddr out; MemAck, MemData in
// Decode side  : InstrValid, Instr, InstrPc out; InstrReady in
// Execute side : Redirect, RedirectTarget in
interface fetch_sequencer_if #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int OFFSET_W = 9
) ();
    logic [ADDR_W-1:0]   PcValue;
    logic                PcLoadEnable;
    logic [ADDR_W-1:0]   PcLoadValue;
    logic                PcOffsetEnable;
    logic [OFFSET_W-1:0] PcOffset;
    logic                MemReq;
    logic [ADDR_W-1:0]   MemAddr;
    logic                MemAck;
    logic [INSTR_W-1:0]  MemData;
    logic                InstrValid;
    logic [INSTR_W-1:0]  Instr;
    logic [ADDR_W-1:0]   InstrPc;
    logic                InstrReady;
    logic                Redirect;
    logic [ADDR_W-1:0]   RedirectTarget;

    modport master (
        input  PcValue, MemAck, MemData, InstrReady, Redirect, RedirectTarget,
        output PcLoadEnable, PcLoadValue, PcOffsetEnable, PcOffset,
               MemReq, MemAddr, InstrValid, Instr, InstrPc
    );

    modport slave (
        output PcValue, MemAck, MemData, InstrReady, Redirect, RedirectTarget,
        input  PcLoadEnable, PcLoadValue, PcOffsetEnable, PcOffset,
               MemReq, MemAddr, InstrValid, Instr, InstrPc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage around an external 16-bit program counter.
// Fetches one word per request over a req/ack memory handshake, presents it to
// decode over valid/ready, and steers the counter so the PC advances once per
// fetched instruction, follows BR relative branches and execute redirects.
//
// Ports:
//   Clock : rising-edge clock
//   Reset : synchronous, active-high reset
//   bus   : fetch_sequencer_if.master (counter, memory, decode, execute signals)
//
// PC control encoding driven to the counter:
//   HOLD   : PcOffsetEnable=1, PcOffset=0 (default)
//   STEP   : both enables 0 (counter increments)
//   BRANCH : PcOffsetEnable=1, PcOffset=Instr[8:0]
//   LOAD   : PcLoadEnable=1, wins over everything else
module fetch_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int OFFSET_W = 9
) (
    input  logic               Clock,
    input  logic               Reset,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, OUTPUT, DRAIN} state_t;

    localparam logic [3:0] OP_BR = 4'hC;

    state_t              state_reg, state_next;
    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic [ADDR_W-1:0]   instr_pc_reg, instr_pc_next;
    logic                instr_valid_reg, instr_valid_next;
    logic [ADDR_W-1:0]   drain_addr_reg, drain_addr_next;

    logic                load_en;
    logic                offset_en;
    logic [OFFSET_W-1:0] offset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg       <= IDLE;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            drain_addr_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            instr_valid_reg <= instr_valid_next;
            drain_addr_reg  <= drain_addr_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        instr_valid_next = instr_valid_reg;
        drain_addr_next  = drain_addr_reg;
        load_en          = 1'b0;
        offset_en        = 1'b1;
        offset           = '0;

        // While Reset is high the counter is told to hold; the registers are
        // being cleared anyway and a redirect must not leak into the PC.
        if (!Reset) begin
            load_en = bus.Redirect;
            case (state_reg)
                IDLE: begin
                    state_next = FETCH;
                end
                FETCH: begin
                    if (bus.Redirect) begin
                        // An ack in the same cycle retires the request, so the
                        // data is simply dropped. Otherwise the request is still
                        // outstanding: remember its address and wait it out.
                        if (!bus.MemAck) begin
                            drain_addr_next = bus.PcValue;
                            state_next      = DRAIN;
                        end
                    end else if (bus.MemAck) begin
                        instr_next       = bus.MemData;
                        instr_pc_next    = bus.PcValue;
                        instr_valid_next = 1'b1;
                        state_next       = OUTPUT;
                        // PC still equals the fetch address here, so adding the
                        // offset now lands on fetch address + offset.
                        if (bus.MemData[INSTR_W-1 -: 4] == OP_BR) begin
                            offset = bus.MemData[OFFSET_W-1:0];
                        end else begin
                            offset_en = 1'b0;
                        end
                    end
                end
                OUTPUT: begin
                    // A redirect flushes the held word even if decode takes it.
                    if (bus.Redirect || bus.InstrReady) begin
                        instr_valid_next = 1'b0;
                        state_next       = FETCH;
                    end
                end
                DRAIN: begin
                    if (bus.MemAck) begin
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.PcLoadEnable   = load_en;
    assign bus.PcLoadValue    = bus.RedirectTarget;
    assign bus.PcOffsetEnable = offset_en;
    assign bus.PcOffset       = offset;
    assign bus.MemReq         = (state_reg == FETCH) || (state_reg == DRAIN);
    // In DRAIN the PC already points at the redirect target, so the abandoned
    // request's address comes from the saved copy to keep MemAddr stable.
    assign bus.MemAddr        = (state_reg == DRAIN) ? drain_addr_reg : bus.PcValue;
    assign bus.InstrValid     = instr_valid_reg;
    assign bus.Instr          = instr_reg;
    assign bus.InstrPc        = instr_pc_reg;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the program counter and a variable-latency
// instruction memory, drives directed scenarios, and checks delivered
// instructions through a scoreboard queue popped by an independent monitor.
module tb_fetch_sequencer;
    localparam int ADDR_W   = 16;
    localparam int INSTR_W  = 16;
    localparam int OFFSET_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFFSET_W(OFFSET_W)) bus ();

    fetch_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .OFFSET_W(OFFSET_W)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- program counter model ----------------
    logic [15:0] pc_q = 16'h0000;
    assign bus.PcValue = pc_q;
    always @(posedge clk) begin
        if (rst)                    pc_q <= 16'h0000;
        else if (bus.PcLoadEnable)  pc_q <= bus.PcLoadValue;
        else if (bus.PcOffsetEnable) pc_q <= pc_q + {{7{bus.PcOffset[8]}}, bus.PcOffset};
        else                        pc_q <= pc_q + 16'h0001;
    end

    // ---------------- instruction memory model ----------------
    logic [15:0] mem_ovr [logic [15:0]];
    int          mem_lat  = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [15:0] mem_addr = 16'h0000;
    logic        ack_q    = 1'b0;
    logic [15:0] data_q   = 16'h0000;
    assign bus.MemAck  = ack_q;
    assign bus.MemData = data_q;

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_ovr.exists(a)) return mem_ovr[a];
        return {4'h1, a[11:0]};
    endfunction

    // Memory ignores reset so a dropped request still gets its late ack.
    always @(posedge clk) begin
        ack_q <= 1'b0;
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                ack_q    <= 1'b1;
                data_q   <= mem_read(mem_addr);
                mem_busy <= 1'b0;
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end else if (bus.MemReq && !ack_q) begin
            if (mem_lat <= 1) begin
                ack_q  <= 1'b1;
                data_q <= mem_read(bus.MemAddr);
            end else begin
                mem_busy <= 1'b1;
                mem_cnt  <= mem_lat - 1;
                mem_addr <= bus.MemAddr;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic accept_now();
        return !rst && bus.InstrValid && bus.InstrReady && !bus.Redirect;
    endfunction

    // Scoreboard monitor: pops on every accepted instruction.
    always @(negedge clk) begin
        if (accept_now()) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got instr 0x%0h pc 0x%0h expected nothing",
                         bus.Instr, bus.InstrPc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("accept instr=0x%04h pc=0x%04h (expected 0x%04h @ 0x%04h)",
                         bus.Instr, bus.InstrPc, e.instr, e.pc);
                chk("sb_instr", {16'h0, bus.Instr}, {16'h0, e.instr});
                chk("sb_pc", {16'h0, bus.InstrPc}, {16'h0, e.pc});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr, input logic [15:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.InstrValid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'h0, bus.InstrValid}, 32'h1);
    endtask

    task automatic wait_accept(input string name, input int budget);
        int n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (accept_now()) seen = 1'b1;
        end
        chk(name, {31'h0, seen}, 32'h1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int steps, bad, acc, n, nbr;
        logic acked;

        bus.InstrReady     = 1'b0;
        bus.Redirect       = 1'b0;
        bus.RedirectTarget = 16'h0000;
        mem_ovr[16'h0010]  = 16'hC1FC;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",  {31'h0, bus.InstrValid}, 32'h0);
        chk("rst_instr",  {16'h0, bus.Instr}, 32'h0);
        chk("rst_pc_out", {16'h0, bus.InstrPc}, 32'h0);
        chk("rst_memreq", {31'h0, bus.MemReq}, 32'h0);
        chk("rst_load",   {31'h0, bus.PcLoadEnable}, 32'h0);
        chk("rst_hold",   {31'h0, bus.PcOffsetEnable}, 32'h1);

        // Sequential fetch with 1-cycle memory and decode always ready.
        tick();
        push(16'h1000, 16'h0000);
        push(16'h1001, 16'h0001);
        push(16'h1002, 16'h0002);
        bus.InstrReady = 1'b1;
        rst = 1'b0;
        steps = 0; bad = 0; acc = 0; n = 0;
        while (acc < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.PcLoadEnable) bad++;
            else if (!bus.PcOffsetEnable) steps++;
            else if (bus.PcOffset != 9'h000) bad++;
            if (accept_now()) acc++;
        end
        chk("t1_accepts", acc, 3);
        chk("t1_steps", steps, 3);
        chk("t1_hold_cycles", bad, 0);
        chk("t1_pc", {16'h0, bus.PcValue}, 32'h3);
        tick();
        bus.InstrReady = 1'b0;

        // Decode stalls for 5 cycles: everything holds, no memory traffic.
        wait_valid("t3_wait", 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_instr",  {16'h0, bus.Instr}, 32'h1003);
            chk("t3_ipc",    {16'h0, bus.InstrPc}, 32'h3);
            chk("t3_memreq", {31'h0, bus.MemReq}, 32'h0);
            chk("t3_pc",     {16'h0, bus.PcValue}, 32'h4);
        end
        tick();
        push(16'h1003, 16'h0003);
        bus.InstrReady = 1'b1;
        wait_accept("t3_accept", 10);
        tick();
        bus.InstrReady = 1'b0;

        // Redirect to 0x0100 while the word is valid and decode is ready.
        wait_valid("t5_wait", 20);
        tick();
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 16'h0100;
        bus.InstrReady     = 1'b1;
        @(negedge clk);
        chk("t5_load",    {31'h0, bus.PcLoadEnable}, 32'h1);
        chk("t5_loadval", {16'h0, bus.PcLoadValue}, 32'h0100);
        tick();
        bus.Redirect = 1'b0;
        push(16'h1100, 16'h0100);
        @(negedge clk);
        chk("t5_flushed", {31'h0, bus.InstrValid}, 32'h0);
        chk("t5_memreq",  {31'h0, bus.MemReq}, 32'h1);
        chk("t5_memaddr", {16'h0, bus.MemAddr}, 32'h0100);
        wait_accept("t5_accept", 10);
        tick();
        bus.InstrReady = 1'b0;

        // BR with offset -4 at 0x0010.
        wait_valid("t2_wait", 20);
        tick();
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 16'h0010;
        tick();
        bus.Redirect   = 1'b0;
        bus.InstrReady = 1'b1;
        push(16'hC1FC, 16'h0010);
        nbr = 0; acc = 0; n = 0;
        while (acc == 0 && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.PcOffsetEnable && !bus.PcLoadEnable && bus.PcOffset != 9'h000) begin
                nbr++;
                chk("t2_offset", {23'h0, bus.PcOffset}, 32'h1FC);
                chk("t2_fetch_addr", {16'h0, bus.MemAddr}, 32'h0010);
            end
            if (accept_now()) acc = 1;
        end
        chk("t2_accepted", acc, 1);
        chk("t2_branch_cycles", nbr, 1);
        tick();
        bus.InstrReady = 1'b0;
        @(negedge clk);
        chk("t2_next_req",  {31'h0, bus.MemReq}, 32'h1);
        chk("t2_next_addr", {16'h0, bus.MemAddr}, 32'h000C);

        // Redirect to 0x4000 during a slow fetch at 0x0020.
        wait_valid("t4_wait", 20);
        tick();
        mem_lat            = 3;
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 16'h0020;
        tick();
        bus.Redirect = 1'b0;
        @(negedge clk);
        chk("t4_fetch_addr", {16'h0, bus.MemAddr}, 32'h0020);
        tick();
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 16'h4000;
        @(negedge clk);
        chk("t4_load",    {31'h0, bus.PcLoadEnable}, 32'h1);
        chk("t4_loadval", {16'h0, bus.PcLoadValue}, 32'h4000);
        chk("t4_addr",    {16'h0, bus.MemAddr}, 32'h0020);
        tick();
        bus.Redirect = 1'b0;
        acked = 1'b0; n = 0;
        while (!acked && n < 10) begin
            @(negedge clk);
            n++;
            chk("t4_drain_addr",  {16'h0, bus.MemAddr}, 32'h0020);
            chk("t4_drain_req",   {31'h0, bus.MemReq}, 32'h1);
            chk("t4_drain_valid", {31'h0, bus.InstrValid}, 32'h0);
            if (bus.MemAck) acked = 1'b1;
        end
        chk("t4_ack_seen", {31'h0, acked}, 32'h1);
        @(negedge clk);
        chk("t4_new_req",   {31'h0, bus.MemReq}, 32'h1);
        chk("t4_new_addr",  {16'h0, bus.MemAddr}, 32'h4000);
        chk("t4_dropped",   {31'h0, bus.InstrValid}, 32'h0);
        tick();
        push(16'h1000, 16'h4000);
        bus.InstrReady = 1'b1;
        wait_accept("t4_accept", 20);
        tick();
        bus.InstrReady = 1'b0;
        mem_lat = 1;

        // PC wrap: non-branch at 0xFFFF steps to 0x0000.
        wait_valid("t6_wait", 20);
        tick();
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 16'hFFFF;
        tick();
        bus.Redirect   = 1'b0;
        bus.InstrReady = 1'b1;
        push(16'h1FFF, 16'hFFFF);
        wait_accept("t6_accept", 10);
        tick();
        bus.InstrReady = 1'b0;
        @(negedge clk);
        chk("t6_wrap_req",  {31'h0, bus.MemReq}, 32'h1);
        chk("t6_wrap_addr", {16'h0, bus.MemAddr}, 32'h0000);

        // Reset while draining; the late ack must be ignored.
        wait_valid("t7_wait", 20);
        tick();
        mem_lat            = 3;
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 16'h0030;
        tick();
        bus.Redirect = 1'b0;
        tick();
        bus.Redirect       = 1'b1;
        bus.RedirectTarget = 16'h0040;
        tick();
        bus.Redirect = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("t7_drain_req",  {31'h0, bus.MemReq}, 32'h1);
        chk("t7_drain_addr", {16'h0, bus.MemAddr}, 32'h0030);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t7_late_ack", {31'h0, bus.MemAck}, 32'h1);
        chk("t7_valid",    {31'h0, bus.InstrValid}, 32'h0);
        chk("t7_instr",    {16'h0, bus.Instr}, 32'h0);
        chk("t7_ipc",      {16'h0, bus.InstrPc}, 32'h0);
        chk("t7_memreq",   {31'h0, bus.MemReq}, 32'h0);
        chk("t7_load",     {31'h0, bus.PcLoadEnable}, 32'h0);
        tick();
        mem_lat = 1;
        push(16'h1000, 16'h0000);
        bus.InstrReady = 1'b1;
        wait_accept("t7_accept", 20);
        tick();
        bus.InstrReady = 1'b0;

        repeat (3) tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
